// File: rtl/htpa_pkg.sv
// Shared types and helpers for the thermal-target slot allocator.
// Box packing is {xo, yo, xn, yn} with the origin corner in the MSBs.
package htpa_pkg;

    localparam int X_W   = 7;
    localparam int Y_W   = 6;
    localparam int BOX_W = 2 * X_W + 2 * Y_W;

    typedef struct packed {
        logic [X_W-1:0] xo;
        logic [Y_W-1:0] yo;
        logic [X_W-1:0] xn;
        logic [Y_W-1:0] yn;
    } box_t;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_SCAN   = 2'd1,
        FSM_COMMIT = 2'd2
    } fsm_e;

    // Inclusive bounds on both axes: boxes sharing an edge pixel overlap.
    function automatic logic boxes_overlap(box_t a, box_t b);
        return (a.xo <= b.xn) && (a.xn >= b.xo) && (a.yo <= b.yn) && (a.yn >= b.yo);
    endfunction

endpackage

// File: rtl/htpa_slot_reg.sv
// One target slot: occupancy, box, fire flag and an age counter that frees
// the slot after MAX_AGE consecutive frames without a matching detection.
module htpa_slot_reg
    import htpa_pkg::*;
#(
    parameter int AGE_W   = 4,
    parameter int MAX_AGE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  box_t load_box,
    input  logic load_fire,
    input  logic age_step,
    output logic busy,
    output box_t box,
    output logic fire,
    output logic freed
);

    logic [AGE_W-1:0] age;

    assign freed = age_step && busy && (age == AGE_W'(MAX_AGE - 1));

    // NOTE: the box payload is reset along with the flags so a freed or
    // never-used slot always presents an all-zero box to the draw logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            box  <= '0;
            fire <= 1'b0;
            age  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            box  <= load_box;
            fire <= load_fire;
            age  <= '0;
        end else if (freed) begin
            busy <= 1'b0;
            box  <= '0;
            fire <= 1'b0;
            age  <= '0;
        end else if (age_step && busy) begin
            age <= age + 1'b1;
        end
    end

endmodule

// File: rtl/htpa_target_alloc.sv
// Target slot allocator: accepts detection boxes, scans the slots one per
// cycle for an overlap or a free entry, then commits in a single cycle.
module htpa_target_alloc
    import htpa_pkg::*;
#(
    parameter int WIDTH   = 19,
    parameter int AGE_W   = 4,
    parameter int MAX_AGE = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_tick,
    input  logic                      det_valid,
    output logic                      det_ready,
    input  logic [BOX_W-1:0]          det_box,
    input  logic                      det_fire,
    output logic [WIDTH:0]            busy,
    output logic [WIDTH:0][BOX_W-1:0] slot_box,
    output logic [WIDTH:0]            slot_fire,
    output logic [4:0]                active_cnt,
    output logic                      det_drop
);

    localparam int NUM_SLOTS = WIDTH + 1;
    localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    localparam logic [1:0] ST_IDLE   = FSM_IDLE;
    localparam logic [1:0] ST_SCAN   = FSM_SCAN;
    localparam logic [1:0] ST_COMMIT = FSM_COMMIT;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] match_idx;
    logic [IDX_W-1:0] free_idx;
    logic             match_found;
    logic             free_found;
    logic             age_pend;
    box_t             det_q;
    logic             fire_q;

    box_t             in_box;
    box_t             cur_box;
    logic             malformed;
    logic             accept;
    logic             hit;
    logic             age_step;
    logic [WIDTH:0]   load;
    logic [WIDTH:0]   freed;
    logic [4:0]       busy_cnt;

    assign in_box    = box_t'(det_box);
    assign malformed = (in_box.xo > in_box.xn) || (in_box.yo > in_box.yn);
    assign det_ready = (state == ST_IDLE) && !age_pend;
    assign accept    = det_valid && det_ready;
    assign cur_box   = box_t'(slot_box[idx]);
    assign hit       = busy[idx] && boxes_overlap(det_q, cur_box);

    // Aging only happens in IDLE, so it can never collide with a COMMIT load.
    assign age_step  = (state == ST_IDLE) && (frame_tick || age_pend);

    // NOTE: defaults first so every path assigns every bit and no latch forms.
    always_comb begin
        load = '0;
        if (state == ST_COMMIT) begin
            if (match_found) begin
                load[match_idx] = 1'b1;
            end else if (free_found) begin
                load[free_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            busy_cnt = busy_cnt + 5'(busy[i]);
        end
    end

    // NOTE: all registered state uses non-blocking assignment so every
    // always_ff reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            match_idx   <= '0;
            free_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            age_pend    <= 1'b0;
            det_q       <= '0;
            fire_q      <= 1'b0;
            det_drop    <= 1'b0;
            active_cnt  <= '0;
        end else begin
            det_drop   <= 1'b0;
            active_cnt <= busy_cnt;
            case (state)
                ST_IDLE: begin
                    age_pend <= 1'b0;
                    if (accept) begin
                        det_q  <= in_box;
                        fire_q <= det_fire;
                        if (malformed) begin
                            det_drop <= 1'b1;
                        end else begin
                            state       <= ST_SCAN;
                            idx         <= '0;
                            match_found <= 1'b0;
                            free_found  <= 1'b0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (frame_tick) age_pend <= 1'b1;
                    if (hit && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!busy[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (idx == IDX_W'(WIDTH)) begin
                        state <= ST_COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (frame_tick) age_pend <= 1'b1;
                    if (!match_found && !free_found) det_drop <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        htpa_slot_reg #(
            .AGE_W  (AGE_W),
            .MAX_AGE(MAX_AGE)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .load_box (det_q),
            .load_fire(fire_q),
            .age_step (age_step),
            .busy     (busy[i]),
            .box      (slot_box[i]),
            .fire     (slot_fire[i]),
            .freed    (freed[i])
        );
    end

endmodule

// File: tb/tb_htpa_target_alloc.sv
// Bench for htpa_target_alloc: directed scenarios plus random traffic,
// checked against a transaction-level slot table model.
module tb_htpa_target_alloc;
    import htpa_pkg::*;

    localparam int WIDTH   = 19;
    localparam int AGE_W   = 4;
    localparam int MAX_AGE = 8;
    localparam int N       = WIDTH + 1;

    logic                      clk        = 1'b0;
    logic                      rst_n      = 1'b0;
    logic                      frame_tick = 1'b0;
    logic                      det_valid  = 1'b0;
    logic [BOX_W-1:0]          det_box    = '0;
    logic                      det_fire   = 1'b0;
    logic                      det_ready;
    logic [WIDTH:0]            busy;
    logic [WIDTH:0][BOX_W-1:0] slot_box;
    logic [WIDTH:0]            slot_fire;
    logic [4:0]                active_cnt;
    logic                      det_drop;

    int total = 0;
    int bad   = 0;

    bit   m_busy[N];
    box_t m_box[N];
    bit   m_fire[N];
    int   m_age[N];

    htpa_target_alloc #(.WIDTH(WIDTH), .AGE_W(AGE_W), .MAX_AGE(MAX_AGE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .det_valid (det_valid),
        .det_ready (det_ready),
        .det_box   (det_box),
        .det_fire  (det_fire),
        .busy      (busy),
        .slot_box  (slot_box),
        .slot_fire (slot_fire),
        .active_cnt(active_cnt),
        .det_drop  (det_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic box_t mk(int xo, int yo, int xn, int yn);
        box_t b;
        b.xo = 7'(xo);
        b.yo = 6'(yo);
        b.xn = 7'(xn);
        b.yn = 6'(yn);
        return b;
    endfunction

    function automatic int m_popc();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_box[i]  = '0;
            m_fire[i] = 0;
            m_age[i]  = 0;
        end
    endtask

    task automatic m_age_step();
        for (int i = 0; i < N; i++) begin
            if (m_busy[i]) begin
                if (m_age[i] + 1 == MAX_AGE) begin
                    m_busy[i] = 0;
                    m_box[i]  = '0;
                    m_fire[i] = 0;
                    m_age[i]  = 0;
                end else begin
                    m_age[i]++;
                end
            end
        end
    endtask

    task automatic m_detect(input box_t b, input bit f, output bit drop);
        int hit = -1;
        int fr  = -1;
        for (int i = 0; i < N; i++) begin
            if (m_busy[i] && int'(b.xo) <= int'(m_box[i].xn) && int'(b.xn) >= int'(m_box[i].xo)
                && int'(b.yo) <= int'(m_box[i].yn) && int'(b.yn) >= int'(m_box[i].yo) && hit < 0)
                hit = i;
            if (!m_busy[i] && fr < 0) fr = i;
        end
        drop = 0;
        if (hit >= 0) begin
            m_box[hit] = b; m_age[hit] = 0; m_fire[hit] = f;
        end else if (fr >= 0) begin
            m_busy[fr] = 1; m_box[fr] = b; m_age[fr] = 0; m_fire[fr] = f;
        end else begin
            drop = 1;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [WIDTH:0] eb;
        logic [WIDTH:0] ef;
        for (int i = 0; i < N; i++) begin
            eb[i] = m_busy[i];
            ef[i] = m_fire[i];
        end
        check({tag, "/busy"}, busy, eb);
        check({tag, "/fire"}, slot_fire, ef);
        for (int i = 0; i < N; i++)
            check($sformatf("%s/box%0d", tag, i), slot_box[i], m_box[i]);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!det_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", det_ready, 1);
    endtask

    // ta/tb_ name scan cycles (1..N+1) on which frame_tick pulses; 0 = none.
    task automatic run_det(input box_t b, input bit f, input int ta, input int tb_);
        bit mal;
        bit drop;
        bit pend;
        int cnt_before;
        wait_ready();
        det_valid = 1'b1;
        det_box   = b;
        det_fire  = f;
        @(negedge clk);
        det_valid = 1'b0;
        det_box   = BOX_W'($urandom);
        det_fire  = 1'($urandom_range(0, 1));
        mal = (b.xo > b.xn) || (b.yo > b.yn);
        if (mal) begin
            check("drop_malformed", det_drop, 1);
            check("ready_malformed", det_ready, 1);
            compare_all("malformed");
            @(negedge clk);
            check("drop_malformed_clear", det_drop, 0);
            return;
        end
        check("ready_low_scan", det_ready, 0);
        pend = 0;
        for (int k = 1; k <= N + 1; k++) begin
            frame_tick = (k == ta) || (k == tb_);
            pend |= frame_tick;
            @(negedge clk);
            if (k == N) begin
                compare_all("pre_commit");
                check("drop_pre_commit", det_drop, 0);
            end
        end
        frame_tick = 1'b0;
        cnt_before = m_popc();
        m_detect(b, f, drop);
        check("drop_commit", det_drop, drop);
        check("ready_after_commit", det_ready, !pend);
        check("cnt_lag", active_cnt, cnt_before);
        compare_all("commit");
        @(negedge clk);
        check("cnt_update", active_cnt, m_popc());
        check("drop_clear", det_drop, 0);
        if (pend) begin
            m_age_step();
            compare_all("scan_tick_age");
            check("ready_after_age", det_ready, 1);
            @(negedge clk);
            check("cnt_after_age", active_cnt, m_popc());
        end
    endtask

    task automatic do_tick();
        int cnt;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cnt = m_popc();
        m_age_step();
        compare_all("tick");
        check("cnt_tick_lag", active_cnt, cnt);
        @(negedge clk);
        check("cnt_tick", active_cnt, m_popc());
    endtask

    initial begin
        m_clear();
        #1;
        compare_all("reset");
        check("reset_cnt", active_cnt, 0);
        check("reset_drop", det_drop, 0);
        check("reset_ready", det_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Allocation into an empty table, then a fire-flagged overlap update.
        run_det(mk(10, 5, 20, 15), 0, 0, 0);
        run_det(mk(18, 12, 30, 20), 1, 0, 0);
        check("fire0_set", slot_fire[0], 1);
        run_det(mk(40, 30, 50, 40), 0, 0, 0);
        check("slot1_busy", busy[1], 1);
        run_det(mk(20, 5, 10, 15), 0, 0, 0);

        // Aging: a match after 7 ticks restarts slot 0's age; slot 1 expires.
        repeat (7) do_tick();
        run_det(mk(18, 12, 30, 20), 1, 0, 0);
        do_tick();
        check("slot1_expired", busy[1], 0);
        repeat (6) do_tick();
        check("slot0_survives", busy[0], 1);
        do_tick();
        check("slot0_expired", busy[0], 0);

        // Two ticks during one scan collapse into a single aging step.
        run_det(mk(5, 5, 8, 8), 0, 3, 10);
        repeat (6) do_tick();
        check("scan_tick_survive", busy[0], 1);
        do_tick();
        check("scan_tick_expire", busy[0], 0);

        // Fill every slot with disjoint boxes, then overflow.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                run_det(mk(c * 25, r * 15, c * 25 + 20, r * 15 + 10), 1'(c & 1), 0, 0);
        check("full_cnt", active_cnt, N);
        run_det(mk(125, 60, 127, 63), 1, 0, 0);

        // Reset in the middle of a scan drops the pending detection.
        wait_ready();
        det_valid = 1'b1;
        det_box   = mk(125, 60, 127, 63);
        @(negedge clk);
        det_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_clear();
        compare_all("midscan_reset");
        check("midscan_cnt", active_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midscan_ready", det_ready, 1);
        repeat (25) @(negedge clk);
        compare_all("no_late_commit");

        // Random traffic.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                int xo = $urandom_range(0, 110);
                int xn = xo + $urandom_range(0, 17);
                int yo = $urandom_range(0, 50);
                int yn = yo + $urandom_range(0, 13);
                int ta = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N + 1) : 0;
                int tb2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N + 1) : 0;
                if ($urandom_range(0, 9) == 0 && xo > 0) xn = xo - 1;
                run_det(mk(xo, yo, xn, yn), 1'($urandom_range(0, 1)), ta, tb2);
            end else begin
                do_tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
